noc_initiator: RTL and testbench

NOC_INITIATOR -- requirements
Module: noc_initiator

---
 rtl/noc_pkg.sv | 54 +++++
 rtl/noc_payload_buf.sv | 45 ++++
 rtl/noc_initiator.sv | 264 ++++++++++++++++++++++++++
 tb/tb_noc_initiator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC command codes, idle byte, initiator state encoding
//               and alen/dlen decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam logic [2:0] c_CMD_IDLE  = 3'b000;
    localparam logic [2:0] c_CMD_READ  = 3'b001;
    localparam logic [2:0] c_CMD_WRITE = 3'b010;
    localparam logic [2:0] c_CMD_RRESP = 3'b011;
    localparam logic [2:0] c_CMD_WRESP = 3'b100;

    localparam logic [7:0] c_IDLE_BYTE = 8'h00;

    localparam int c_BUF_DEPTH = 128;
    localparam int c_PTR_W     = 7;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_HDR    = 4'd2,
        S_DID    = 4'd3,
        S_SID    = 4'd4,
        S_ADDR   = 4'd5,
        S_DATA   = 4'd6,
        S_WAIT   = 4'd7,
        S_R_DID  = 4'd8,
        S_R_SID  = 4'd9,
        S_R_DATA = 4'd10
    } noc_state_e;

    function automatic logic [3:0] alen_bytes(input logic [1:0] alen);
        return 4'd1 << alen;
    endfunction

    // Index of the final address byte (0..7)
    function automatic logic [2:0] alen_last(input logic [1:0] alen);
        return 3'(alen_bytes(alen) - 4'd1);
    endfunction

    function automatic logic [7:0] dlen_bytes(input logic [2:0] dlen);
        return 8'd1 << dlen;
    endfunction

    // Index of the final data byte (0..127)
    function automatic logic [6:0] dlen_last(input logic [2:0] dlen);
        return 7'(dlen_bytes(dlen) - 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_payload_buf.sv
`default_nettype none
// ============================================================================
// Module      : noc_payload_buf
// Description : 128x8 write-payload buffer with independent write/read
//               pointers and a synchronous pointer clear.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_payload_buf
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data
);

    logic [7:0]         r_mem [0:c_BUF_DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers define which entries are meaningful
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/noc_initiator.sv
`default_nettype none
// ============================================================================
// Module      : noc_initiator
// Description : Single-outstanding NoC initiator: serialises read/write
//               commands onto the byte line and collects the response.
//               Define NOC_RSP_TIMEOUT_EN to bound the wait for a response.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_initiator
    import noc_pkg::*;
#(
    parameter logic [7:0] MY_ID       = 8'h01,
    parameter int         RSP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_alen,
    input  logic [2:0]  req_dlen,
    input  logic [7:0]  req_dest,
    input  logic [63:0] req_addr,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    output logic        noc_to_dev_ctl,
    output logic [7:0]  noc_to_dev_data,
    input  logic        noc_from_dev_ctl,
    input  logic [7:0]  noc_from_dev_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_last,
    output logic        rsp_write,
    output logic        rsp_err
);

    noc_state_e  r_state, w_state_nxt;
    logic        r_live;
    logic [1:0]  r_alen;
    logic [2:0]  r_dlen;
    logic [7:0]  r_dest;
    logic [63:0] r_addr;
    logic        r_write;
    logic [6:0]  r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic        r_rsp_is_wr, w_rsp_is_wr_nxt;

    logic        r_rsp_valid, r_rsp_last, r_rsp_write, r_rsp_err;
    logic [7:0]  r_rsp_data;

    logic        w_accept, w_buf_clr, w_buf_wr, w_buf_rd, w_abort, w_timeout;
    logic [7:0]  w_buf_rd_data;
    logic        w_ev_valid, w_ev_last, w_ev_err;
    logic [7:0]  w_ev_data;
    logic [2:0]  w_rx_cmd;
    logic [2:0]  w_alast;
    logic [6:0]  w_dlast;
    logic [7:0]  w_dbytes;

    assign w_rx_cmd = noc_from_dev_data[2:0];
    assign w_alast  = alen_last(r_alen);
    assign w_dlast  = dlen_last(r_dlen);
    assign w_dbytes = dlen_bytes(r_dlen);
    assign w_abort  = noc_from_dev_ctl &&
                      (r_state == S_R_DID || r_state == S_R_SID || r_state == S_R_DATA);

`ifdef NOC_RSP_TIMEOUT_EN
    localparam int c_TO_W = $clog2(RSP_TIMEOUT + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_to_cnt <= '0;
        else if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + 1'b1;
        else                       r_to_cnt <= '0;
    end

    assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == c_TO_W'(RSP_TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^RSP_TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    noc_payload_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_buf_clr),
        .wr_en   (w_buf_wr),
        .wr_data (wr_data),
        .rd_en   (w_buf_rd),
        .rd_data (w_buf_rd_data)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_err_nxt        = r_err;
        w_rsp_is_wr_nxt  = r_rsp_is_wr;
        w_accept         = 1'b0;
        w_buf_clr        = 1'b0;
        w_buf_wr         = 1'b0;
        w_buf_rd         = 1'b0;
        wr_ready         = 1'b0;
        noc_to_dev_ctl   = 1'b1;
        noc_to_dev_data  = c_IDLE_BYTE;
        w_ev_valid       = 1'b0;
        w_ev_data        = 8'h00;
        w_ev_last        = 1'b0;
        w_ev_err         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_live && req_valid) begin
                    w_accept    = 1'b1;
                    w_buf_clr   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = req_write ? S_LOAD : S_HDR;
                end
            end
            S_LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    w_buf_wr = 1'b1;
                    if (r_cnt == w_dlast) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HDR;
                    end else begin
                        w_cnt_nxt = r_cnt + 7'd1;
                    end
                end
            end
            S_HDR: begin
                noc_to_dev_data = {r_alen, r_dlen, r_write ? c_CMD_WRITE : c_CMD_READ};
                w_state_nxt     = S_DID;
            end
            S_DID: begin
                noc_to_dev_ctl  = 1'b0;
                noc_to_dev_data = r_dest;
                w_state_nxt     = S_SID;
            end
            S_SID: begin
                noc_to_dev_ctl  = 1'b0;
                noc_to_dev_data = MY_ID;
                w_state_nxt     = S_ADDR;
            end
            S_ADDR: begin
                noc_to_dev_ctl  = 1'b0;
                noc_to_dev_data = r_addr[{r_cnt[2:0], 3'b000} +: 8];
                if (r_cnt[2:0] == w_alast) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_write ? S_DATA : S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 7'd1;
                end
            end
            S_DATA: begin
                noc_to_dev_ctl  = 1'b0;
                noc_to_dev_data = w_buf_rd_data;
                w_buf_rd        = 1'b1;
                if (r_cnt == w_dlast) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 7'd1;
                end
            end
            S_WAIT: begin
                if (noc_from_dev_ctl && (w_rx_cmd == c_CMD_RRESP || w_rx_cmd == c_CMD_WRESP)) begin
                    w_rsp_is_wr_nxt = (w_rx_cmd == c_CMD_WRESP);
                    w_err_nxt       = r_err | ((w_rx_cmd == c_CMD_WRESP) != r_write);
                    w_state_nxt     = S_R_DID;
                end else if (w_timeout) begin
                    w_ev_valid  = 1'b1;
                    w_ev_last   = 1'b1;
                    w_ev_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_R_DID: begin
                if (noc_from_dev_data != MY_ID) w_err_nxt = 1'b1;
                w_state_nxt = S_R_SID;
            end
            S_R_SID: begin
                if (noc_from_dev_data != r_dest) w_err_nxt = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_R_DATA;
            end
            S_R_DATA: begin
                w_ev_valid = 1'b1;
                w_ev_data  = noc_from_dev_data;
                if (r_rsp_is_wr) begin
                    // Write response carries the count of bytes the target accepted
                    w_ev_last   = 1'b1;
                    w_ev_err    = r_err | (noc_from_dev_data != w_dbytes);
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == w_dlast) begin
                    w_ev_last   = 1'b1;
                    w_ev_err    = r_err;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 7'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A header byte inside a response body truncates it
        if (w_abort) begin
            w_ev_valid  = 1'b1;
            w_ev_data   = 8'h00;
            w_ev_last   = 1'b1;
            w_ev_err    = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_alen      <= '0;
            r_dlen      <= '0;
            r_dest      <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rsp_is_wr <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_live      <= 1'b1;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_rsp_is_wr <= w_rsp_is_wr_nxt;
            if (w_accept) begin
                r_alen  <= req_alen;
                r_dlen  <= req_dlen;
                r_dest  <= req_dest;
                r_addr  <= req_addr;
                r_write <= req_write;
            end
            r_rsp_valid <= w_ev_valid;
            r_rsp_data  <= w_ev_data;
            r_rsp_last  <= w_ev_last;
            r_rsp_err   <= w_ev_err;
            r_rsp_write <= w_ev_valid & r_write;
        end
    end

    assign req_ready = (r_state == S_IDLE) && r_live;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;
    assign rsp_write = r_rsp_write;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_initiator
// Description : Randomised self-checking bench for noc_initiator against a
//               transaction-level model of the line and response protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_initiator;

    localparam logic [7:0] MY_ID       = 8'h01;
    localparam int         RSP_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_alen = '0;
    logic [2:0]  req_dlen = '0;
    logic [7:0]  req_dest = '0;
    logic [63:0] req_addr = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_data = '0;
    logic        noc_to_dev_ctl;
    logic [7:0]  noc_to_dev_data;
    logic        noc_from_dev_ctl = 1'b1;
    logic [7:0]  noc_from_dev_data = '0;
    logic        rsp_valid, rsp_last, rsp_write, rsp_err;
    logic [7:0]  rsp_data;

    noc_initiator #(.MY_ID(MY_ID), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_alen(req_alen), .req_dlen(req_dlen), .req_dest(req_dest), .req_addr(req_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .noc_to_dev_ctl(noc_to_dev_ctl), .noc_to_dev_data(noc_to_dev_data),
        .noc_from_dev_ctl(noc_from_dev_ctl), .noc_from_dev_data(noc_from_dev_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_write(rsp_write), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic        write;
        logic        err;
        int unsigned c;
    } ev_t;

    ev_t         ev_q[$];
    logic [8:0]  line_q[$];
    int unsigned line_c[$];
    logic [7:0]  payload_q[$];
    logic [7:0]  rd_q[$];
    ev_t         mon_e;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ev_t mk_ev(input logic [7:0] d, input logic l, input logic w, input logic e);
        ev_t r;
        r.data = d; r.last = l; r.write = w; r.err = e; r.c = 0;
        return r;
    endfunction

    // Capture every non-idle line byte and every response event
    always @(negedge clk) begin
        if (rst) begin
            if (!(noc_to_dev_ctl && noc_to_dev_data == 8'h00)) begin
                line_q.push_back({noc_to_dev_ctl, noc_to_dev_data});
                line_c.push_back(cyc);
            end
            if (rsp_valid) begin
                mon_e.data = rsp_data; mon_e.last = rsp_last;
                mon_e.write = rsp_write; mon_e.err = rsp_err; mon_e.c = cyc;
                ev_q.push_back(mon_e);
            end
        end
    end

    task automatic fill_random();
        payload_q.delete(); rd_q.delete();
        for (int i = 0; i < 128; i++) begin
            payload_q.push_back(8'($urandom));
            rd_q.push_back(8'($urandom));
        end
    endtask

    task automatic run_txn(input string tag, input bit wr, input logic [1:0] alen,
                           input logic [2:0] dlen, input logic [7:0] dest, input logic [63:0] addr,
                           input bit rwr, input logic [7:0] did, input logic [7:0] sid,
                           input logic [7:0] wcount, input int abort_at, input bit noresp);
        int          n, na, t;
        int unsigned acc_c, wait_c;
        bit          err;
        logic [2:0]  jc;
        logic [8:0]  exp_line[$];
        logic [7:0]  body[$];
        ev_t         exp_ev[$];
        n  = 1 << dlen;
        na = 1 << alen;
        line_q.delete(); line_c.delete(); ev_q.delete();

        t = 0;
        while (!req_ready && t < 200) begin step(); t++; end
        check_eq({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_alen = alen; req_dlen = dlen;
        req_dest = dest; req_addr = addr;
        step();
        req_valid = 1'b0;
        acc_c = cyc;

        if (wr) begin
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) step();
                if (i == 0) check_eq({tag, ".wr_ready"}, 64'(wr_ready), 64'd1);
                wr_valid = 1'b1; wr_data = payload_q[i];
                step();
                wr_valid = 1'b0;
            end
        end

        exp_line.push_back({1'b1, alen, dlen, wr ? 3'b010 : 3'b001});
        exp_line.push_back({1'b0, dest});
        exp_line.push_back({1'b0, MY_ID});
        for (int i = 0; i < na; i++) exp_line.push_back({1'b0, addr[8*i +: 8]});
        if (wr) for (int i = 0; i < n; i++) exp_line.push_back({1'b0, payload_q[i]});

        t = 0;
        while (line_q.size() < exp_line.size() && t < 400) begin step(); t++; end
        step();
        check_eq({tag, ".line_len"}, 64'(line_q.size()), 64'(exp_line.size()));
        for (int i = 0; i < exp_line.size() && i < line_q.size(); i++) begin
            check_eq($sformatf("%s.line%0d", tag, i), 64'(line_q[i]), 64'(exp_line[i]));
            if (i > 0) check_eq($sformatf("%s.gap%0d", tag, i), 64'(line_c[i] - line_c[0]), 64'(i));
        end
        if (!wr && line_c.size() > 0)
            check_eq({tag, ".hdr_cycle"}, 64'(line_c[0]), 64'(acc_c));
        wait_c = (line_c.size() > 0) ? line_c[line_c.size()-1] + 1 : 0;

        if (noresp) begin
`ifdef NOC_RSP_TIMEOUT_EN
            exp_ev.push_back(mk_ev(8'h00, 1'b1, wr, 1'b1));
`endif
        end else begin
            body.push_back(did);
            body.push_back(sid);
            if (rwr) body.push_back(wcount);
            else for (int i = 0; i < n; i++) body.push_back(rd_q[i]);
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 1) == 1) begin
                do jc = 3'($urandom_range(0, 7)); while (jc == 3'b011 || jc == 3'b100);
                noc_from_dev_ctl = 1'b1; noc_from_dev_data = {5'($urandom), jc};
                step();
            end
            noc_from_dev_ctl = 1'b1; noc_from_dev_data = {alen, dlen, rwr ? 3'b100 : 3'b011};
            step();
            for (int i = 0; i < body.size(); i++) begin
                if (i == abort_at) begin
                    noc_from_dev_ctl = 1'b1; noc_from_dev_data = 8'h00;
                    step();
                    break;
                end
                noc_from_dev_ctl = 1'b0; noc_from_dev_data = body[i];
                step();
            end
            noc_from_dev_ctl = 1'b1; noc_from_dev_data = 8'h00;

            err = (rwr != wr) || (did != MY_ID) || (sid != dest);
            if (abort_at >= 0 && abort_at < body.size()) begin
                for (int i = 2; i < abort_at; i++) exp_ev.push_back(mk_ev(body[i], 1'b0, wr, 1'b0));
                exp_ev.push_back(mk_ev(8'h00, 1'b1, wr, 1'b1));
            end else if (rwr) begin
                exp_ev.push_back(mk_ev(wcount, 1'b1, wr, err || (wcount != 8'(n))));
            end else begin
                for (int i = 0; i < n; i++)
                    exp_ev.push_back(mk_ev(rd_q[i], i == n-1, wr, (i == n-1) && err));
            end
        end

        t = 0;
        while (ev_q.size() < exp_ev.size() && t < 300) begin step(); t++; end
        repeat (3) step();
        check_eq({tag, ".ev_count"}, 64'(ev_q.size()), 64'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++)
            check_eq($sformatf("%s.ev%0d{data,last,write,err}", tag, i),
                     64'({ev_q[i].data, ev_q[i].last, ev_q[i].write, ev_q[i].err}),
                     64'({exp_ev[i].data, exp_ev[i].last, exp_ev[i].write, exp_ev[i].err}));
`ifdef NOC_RSP_TIMEOUT_EN
        if (noresp && ev_q.size() > 0)
            check_eq({tag, ".timeout_cycles"}, 64'(ev_q[0].c - wait_c), 64'(RSP_TIMEOUT));
`endif
        check_eq({tag, ".ready_after"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) step();
        check_eq("rst.ctl", 64'(noc_to_dev_ctl), 64'd1);
        check_eq("rst.data", 64'(noc_to_dev_data), 64'd0);
        check_eq("rst.req_ready", 64'(req_ready), 64'd0);
        check_eq("rst.wr_ready", 64'(wr_ready), 64'd0);
        check_eq("rst.rsp", 64'({rsp_valid, rsp_last, rsp_err, rsp_write, rsp_data}), 64'd0);
        rst = 1'b1;
        step();
        check_eq("rst.ready_rise", 64'(req_ready), 64'd1);

        // Directed scenarios
        fill_random();
        rd_q[0] = 8'hAA;
        run_txn("rd_basic", 1'b0, 2'd0, 3'd0, 8'h05, 64'h3C, 1'b0, MY_ID, 8'h05, 8'h00, -1, 1'b0);
        payload_q[0] = 8'h11; payload_q[1] = 8'h22; payload_q[2] = 8'h33; payload_q[3] = 8'h44;
        run_txn("wr_basic", 1'b1, 2'd1, 3'd2, 8'h22, 64'h1234, 1'b1, MY_ID, 8'h22, 8'd4, -1, 1'b0);
        run_txn("wr_badcnt", 1'b1, 2'd1, 3'd2, 8'h22, 64'h1234, 1'b1, MY_ID, 8'h22, 8'd3, -1, 1'b0);
        run_txn("rd_badsid", 1'b0, 2'd0, 3'd0, 8'h05, 64'h3C, 1'b0, MY_ID, 8'h07, 8'h00, -1, 1'b0);
        run_txn("wr_128", 1'b1, 2'd3, 3'd7, 8'h9A, 64'h0123456789ABCDEF, 1'b1, MY_ID, 8'h9A, 8'd128, -1, 1'b0);
`ifdef NOC_RSP_TIMEOUT_EN
        run_txn("timeout", 1'b0, 2'd2, 3'd1, 8'h33, 64'hCAFE, 1'b0, MY_ID, 8'h33, 8'h00, -1, 1'b1);
`endif

        // Randomised transactions with assorted response faults
        for (int k = 0; k < 30; k++) begin
            bit         wr, rwr;
            logic [1:0] al;
            logic [2:0] dl;
            logic [7:0] dest, did, sid, cnt;
            int         mode, ab, bsz;
            fill_random();
            wr = 1'($urandom); al = 2'($urandom); dl = 3'($urandom_range(0, 5));
            dest = 8'($urandom); rwr = wr; did = MY_ID; sid = dest;
            cnt = 8'(1 << dl); ab = -1;
            mode = $urandom_range(0, 9);
            if (mode == 6) rwr = !wr;
            else if (mode == 7) begin
                if ($urandom_range(0, 1) == 1) did = ~MY_ID; else sid = ~dest;
            end else if (mode == 8) cnt = cnt + 8'd1;
            else if (mode == 9) begin
                bsz = 2 + (rwr ? 1 : (1 << dl));
                ab = $urandom_range(0, bsz - 1);
            end
            run_txn($sformatf("rnd%0d", k), wr, al, dl, dest, {$urandom, $urandom},
                    rwr, did, sid, cnt, ab, 1'b0);
        end

        // Reset in the middle of the write payload
        fill_random();
        line_q.delete(); line_c.delete(); ev_q.delete();
        req_valid = 1'b1; req_write = 1'b1; req_alen = 2'd0; req_dlen = 3'd4;
        req_dest = 8'h44; req_addr = 64'h77;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = payload_q[i];
            step();
        end
        wr_valid = 1'b0;
        t = 0;
        while (line_q.size() < 8 && t < 100) begin step(); t++; end
        check_eq("mid.in_data", 64'(noc_to_dev_ctl), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid.ctl", 64'(noc_to_dev_ctl), 64'd1);
        check_eq("mid.data", 64'(noc_to_dev_data), 64'd0);
        check_eq("mid.req_ready", 64'(req_ready), 64'd0);
        check_eq("mid.rsp_valid", 64'(rsp_valid), 64'd0);
        step(); step();
        rst = 1'b1;
        step();
        check_eq("mid.ready_back", 64'(req_ready), 64'd1);
        check_eq("mid.no_rsp", 64'(ev_q.size()), 64'd0);
        rd_q[0] = 8'h5A; rd_q[1] = 8'hA5;
        run_txn("after_rst", 1'b0, 2'd1, 3'd1, 8'h10, 64'hBEEF, 1'b0, MY_ID, 8'h10, 8'h00, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
